// File: rtl/hour_counter_24.sv
// Hour stage of the digital clock: 00..23 binary count with edge-detected
// carry/set inputs, a one-cycle day carry and a registered 12h/24h BCD display.
module hour_counter_24 #(
    parameter int unsigned RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carry_in,
    input  logic       set_en,
    input  logic       set_up,
    input  logic       set_down,
    input  logic       mode_12h,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       pm,
    output logic       day_carry
);

    localparam logic [4:0] MAX_HOUR    = 5'd23;
    localparam logic [4:0] NOON_HOUR   = 5'd12;
    localparam logic [4:0] RESET_COUNT = 5'(RESET_HOUR);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC
    } count_op_e;

    logic       carry_prev_q;
    logic       up_prev_q;
    logic       down_prev_q;
    logic       rise_carry;
    logic       rise_up;
    logic       rise_down;
    count_op_e  count_op;

    logic [4:0] count_q;
    logic [4:0] count_d;
    logic       wrap_q;
    logic       wrap_d;
    logic       day_carry_q;

    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] ones_q;
    logic [3:0] ones_d;
    logic       pm_q;
    logic       pm_d;

    // Displayed hour value: identity in 24h mode, 1..12 in 12h mode.
    function automatic logic [4:0] display_value(input logic [4:0] count,
                                                 input logic       is_12h);
        logic [4:0] value;
        value = count;
        if (is_12h) begin
            if (count == 5'd0 || count == NOON_HOUR) begin
                value = NOON_HOUR;
            end else if (count > NOON_HOUR) begin
                value = count - NOON_HOUR;
            end
        end
        return value;
    endfunction

    // Binary 0..23 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [4:0] value);
        logic [7:0] digits;
        if (value >= 5'd20) begin
            digits = {4'd2, 4'(value - 5'd20)};
        end else if (value >= 5'd10) begin
            digits = {4'd1, 4'(value - 5'd10)};
        end else begin
            digits = {4'd0, 4'(value)};
        end
        return digits;
    endfunction

    assign rise_carry = carry_in & ~carry_prev_q;
    assign rise_up    = set_up   & ~up_prev_q;
    assign rise_down  = set_down & ~down_prev_q;

    // In set mode a carry edge is dropped outright, and simultaneous up/down cancel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_op = OP_HOLD;
        if (!set_en) begin
            if (rise_carry) begin
                count_op = OP_INC;
            end
        end else if (rise_up && !rise_down) begin
            count_op = OP_INC;
        end else if (rise_down && !rise_up) begin
            count_op = OP_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (count_op)
            OP_INC: begin
                if (count_q == MAX_HOUR) begin
                    count_d = 5'd0;
                    wrap_d  = ~set_en;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            OP_DEC: begin
                count_d = (count_q == 5'd0) ? MAX_HOUR : count_q - 5'd1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_comb begin
        {tens_d, ones_d} = to_bcd(display_value(count_q, mode_12h));
        pm_d             = (count_q >= NOON_HOUR);
    end

    // The day carry travels with the display so it lines up with the shown 00.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count_q      <= RESET_COUNT;
            carry_prev_q <= 1'b1;
            up_prev_q    <= 1'b1;
            down_prev_q  <= 1'b1;
            wrap_q       <= 1'b0;
            day_carry_q  <= 1'b0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            pm_q         <= 1'b0;
        end else begin
            count_q      <= count_d;
            carry_prev_q <= carry_in;
            up_prev_q    <= set_up;
            down_prev_q  <= set_down;
            wrap_q       <= wrap_d;
            day_carry_q  <= wrap_q;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            pm_q         <= pm_d;
        end
    end

    assign hour_tens = tens_q;
    assign hour_ones = ones_q;
    assign pm        = pm_q;
    assign day_carry = day_carry_q;

endmodule
